// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared state enumeration and constants for the fetch sequencer
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } fetch_state_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_seq_if.sv
// rtl/fetch_seq_if.sv - IF-stage control bundle between pipeline/memory and the fetch sequencer
interface fetch_seq_if;
  logic hazard_freeze;
  logic branch_taken;
  logic imem_ack;
  logic imem_req;
  logic pc_freeze;
  logic pc_sel;
  logic ifid_flush;
  logic ifid_valid;
  logic err;

  modport master (
    output hazard_freeze, branch_taken, imem_ack,
    input  imem_req, pc_freeze, pc_sel, ifid_flush, ifid_valid, err
  );

  modport slave (
    input  hazard_freeze, branch_taken, imem_ack,
    output imem_req, pc_freeze, pc_sel, ifid_flush, ifid_valid, err
  );
endinterface

// File: rtl/fetch_seq_wait_timer.sv
// rtl/fetch_seq_wait_timer.sv - saturating memory-wait counter; expired flags the miss that reaches TIMEOUT
module fetch_seq_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && count_q != LIMIT)
      count_d = count_q + 1'b1;
  end

  assign expired = inc && !clr && (count_d == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - IF-stage fetch control FSM (BOOT/FETCH/HOLD/ERROR)
// Optional perf counters stall_count/redirect_count under FETCH_SEQ_PERF_EN.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  fetch_seq_if.slave  bus
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] redirect_count
`endif
);
  fetch_state_e state_q, state_d;
  logic         tmr_clr, tmr_inc, tmr_expired;

  fetch_seq_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= BOOT;
    else
      state_q <= state_d;
  end

  // Priority inside FETCH/HOLD: redirect, then hazard, then memory ack/timeout.
  always_comb begin
    state_d        = state_q;
    tmr_clr        = 1'b0;
    tmr_inc        = 1'b0;
    bus.imem_req   = 1'b0;
    bus.pc_freeze  = 1'b1;
    bus.pc_sel     = 1'b0;
    bus.ifid_flush = 1'b0;
    bus.ifid_valid = 1'b0;
    bus.err        = 1'b0;
    unique case (state_q)
      BOOT: begin
        tmr_clr = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.branch_taken) begin
          bus.pc_sel     = 1'b1;
          bus.pc_freeze  = 1'b0;
          bus.ifid_flush = 1'b1;
          tmr_clr        = 1'b1;
        end else if (bus.hazard_freeze) begin
          tmr_clr = 1'b1;
          state_d = HOLD;
        end else if (bus.imem_ack) begin
          bus.pc_freeze  = 1'b0;
          bus.ifid_valid = 1'b1;
          tmr_clr        = 1'b1;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_expired)
            state_d = ERROR;
        end
      end
      HOLD: begin
        tmr_clr = 1'b1;
        if (bus.branch_taken) begin
          bus.pc_sel     = 1'b1;
          bus.pc_freeze  = 1'b0;
          bus.ifid_flush = 1'b1;
          state_d        = FETCH;
        end else if (!bus.hazard_freeze) begin
          state_d = FETCH;
        end
      end
      ERROR: begin
        bus.err = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] stall_q, redirect_q;
  logic        stall_hit;

  assign stall_hit = (state_q == FETCH || state_q == HOLD) && bus.pc_freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q    <= '0;
      redirect_q <= '0;
    end else begin
      if (stall_hit && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (bus.pc_sel && redirect_q != '1)
        redirect_q <= redirect_q + 32'd1;
    end
  end

  assign stall_count    = stall_q;
  assign redirect_count = redirect_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized + directed bench for fetch_sequencer against a behavioural model
module tb_fetch_sequencer;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_seq_if bus ();

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] stall_count, redirect_count;
`endif

  fetch_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .stall_count    (stall_count),
    .redirect_count (redirect_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: what the pipeline is doing, not how the FSM encodes it.
  bit          m_booting;
  bit          m_holding;
  bit          m_dead;
  int          m_misses;
  longint      m_stalls;
  longint      m_redirects;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_booting   = 1'b1;
    m_holding   = 1'b0;
    m_dead      = 1'b0;
    m_misses    = 0;
    m_stalls    = 0;
    m_redirects = 0;
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic apply_reset();
    rst = 1'b1;
    #4;
    check("rst_imem_req",   bus.imem_req,   1'b0);
    check("rst_pc_freeze",  bus.pc_freeze,  1'b1);
    check("rst_pc_sel",     bus.pc_sel,     1'b0);
    check("rst_ifid_flush", bus.ifid_flush, 1'b0);
    check("rst_ifid_valid", bus.ifid_valid, 1'b0);
    check("rst_err",        bus.err,        1'b0);
`ifdef FETCH_SEQ_PERF_EN
    check("rst_stall_count",    stall_count,    32'd0);
    check("rst_redirect_count", redirect_count, 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cycle(input bit hz, input bit br, input bit ack);
    bit e_req, e_fr, e_sel, e_fl, e_v, e_err;
    bus.hazard_freeze = hz;
    bus.branch_taken  = br;
    bus.imem_ack      = ack;
    #4;
    e_req = 0; e_fr = 1; e_sel = 0; e_fl = 0; e_v = 0; e_err = 0;
    if (m_dead) begin
      e_err = 1;
    end else if (!m_booting) begin
      e_req = !m_holding;
      if (br) begin
        e_sel = 1; e_fr = 0; e_fl = 1;
      end else if (!m_holding && !hz && ack) begin
        e_fr = 0; e_v = 1;
      end
    end
    check("imem_req",   bus.imem_req,   e_req);
    check("pc_freeze",  bus.pc_freeze,  e_fr);
    check("pc_sel",     bus.pc_sel,     e_sel);
    check("ifid_flush", bus.ifid_flush, e_fl);
    check("ifid_valid", bus.ifid_valid, e_v);
    check("err",        bus.err,        e_err);
`ifdef FETCH_SEQ_PERF_EN
    check("stall_count",    stall_count,    32'(m_stalls));
    check("redirect_count", redirect_count, 32'(m_redirects));
`endif
    if (!m_booting && !m_dead && e_fr) m_stalls++;
    if (e_sel) m_redirects++;
    if (m_booting) begin
      m_booting = 0;
      m_misses  = 0;
    end else if (!m_dead) begin
      if (br) begin
        m_holding = 0; m_misses = 0;
      end else if (m_holding) begin
        m_holding = hz; m_misses = 0;
      end else if (hz) begin
        m_holding = 1; m_misses = 0;
      end else if (ack) begin
        m_misses = 0;
      end else begin
        m_misses++;
        if (m_misses >= TIMEOUT) m_dead = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hazard_freeze = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.imem_ack      = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Streaming fetch straight out of reset: BOOT then eight instructions.
    for (int i = 0; i < 9; i++) cycle(0, 0, 1);
    check("stream_err", bus.err, 1'b0);

    // Three misses then an ack, followed by one redirect.
    apply_reset();
    cycle(0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 1, 0);
`ifdef FETCH_SEQ_PERF_EN
    check("perf_stall_3",    stall_count,    32'd3);
    check("perf_redirect_1", redirect_count, 32'd1);
`endif

    // Timeout into ERROR; branches there are ignored; reset recovers.
    for (int i = 0; i < TIMEOUT; i++) cycle(0, 0, 0);
    cycle(0, 1, 1);
    cycle(1, 1, 0);
    check("error_sticky", bus.err, 1'b1);
    apply_reset();
    cycle(0, 0, 1);
    cycle(0, 0, 1);

    // TIMEOUT-1 misses, then a branch on the would-be timeout cycle wins.
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 0, 0);
    cycle(0, 1, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 0, 0);
    cycle(0, 0, 1);

    // Hazard for two cycles, then release.
    cycle(1, 0, 1);
    cycle(1, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);

    // Branch together with hazard while in HOLD.
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(0, 0, 1);

    // Reset in the middle of a wait.
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    apply_reset();

    // Randomized segments with varying ack density.
    for (int seg = 0; seg < 20; seg++) begin
      int ack_pct;
      ack_pct = (seg % 4 == 3) ? 0 : int'($urandom_range(30, 95));
      for (int i = 0; i < 40; i++) begin
        bit hz, br, ack;
        hz  = ($urandom_range(0, 99) < 15);
        br  = ($urandom_range(0, 99) < 8);
        ack = ($urandom_range(0, 99) < ack_pct);
        cycle(hz, br, ack);
      end
      if ($urandom_range(0, 2) == 0) apply_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: maximum consecutive cycles the block waits for imem_ack before it enters ERROR.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the wait counter, which SHALL hold TIMEOUT.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port hazard_freeze, input, 1 bit: data-hazard stall request from the decode/hazard unit.
REQ-006 The block SHALL have port branch_taken, input, 1 bit: resolved taken branch from downstream.
REQ-007 The block SHALL have port imem_ack, input, 1 bit: instruction memory returns the instruction for the current PC this cycle.
REQ-008 The block SHALL have port imem_req, output, 1 bit: fetch request for the current PC.
REQ-009 The block SHALL have port pc_freeze, output, 1 bit: drives the IF-stage PC register freeze.
REQ-010 The block SHALL have port pc_sel, output, 1 bit: drives the IF-stage branch-token mux select.
REQ-011 The block SHALL have port ifid_flush, output, 1 bit: clears the IF/ID pipeline register.
REQ-012 The block SHALL have port ifid_valid, output, 1 bit: the IF/ID register captures a valid instruction this cycle.
REQ-013 The block SHALL have port err, output, 1 bit: sticky memory-timeout error.

Function
REQ-014 The FSM SHALL have states BOOT, FETCH, HOLD and ERROR; state and wait counter SHALL be registered, and outputs SHALL be combinational from state and inputs.
REQ-015 BOOT SHALL drive imem_req=0, pc_freeze=1, pc_sel=0, ifid_flush=0 and ifid_valid=0, and SHALL go to FETCH unconditionally after one cycle.
REQ-016 FETCH SHALL drive imem_req=1.
REQ-017 In FETCH, imem_ack=1 with hazard_freeze=0 and branch_taken=0 SHALL give pc_freeze=0 and ifid_valid=1, clear the counter, and stay in FETCH: one instruction per cycle.
REQ-018 In FETCH, imem_ack=0 SHALL give pc_freeze=1 and ifid_valid=0, increment the counter, and go to ERROR when the counter reaches TIMEOUT.
REQ-019 In FETCH, hazard_freeze=1 with branch_taken=0 SHALL give pc_freeze=1 and ifid_valid=0 and go to HOLD, regardless of imem_ack.
REQ-020 HOLD SHALL drive imem_req=0, pc_freeze=1 and ifid_valid=0, and SHALL return to FETCH with the counter cleared in the cycle after hazard_freeze falls.
REQ-021 branch_taken=1 in FETCH or HOLD SHALL give pc_sel=1, pc_freeze=0, ifid_flush=1 and ifid_valid=0, clear the counter, and go to FETCH in the same cycle.
REQ-022 branch_taken SHALL take priority over hazard_freeze, over imem_ack, and over a timeout reached in the same cycle.
REQ-023 branch_taken SHALL be ignored in BOOT and ERROR, with pc_sel=0 in those states.
REQ-024 No memory transaction SHALL be outstanding across a redirect; imem_ack SHALL always refer to the PC presented in the same cycle.
REQ-025 ERROR SHALL drive imem_req=0, pc_freeze=1 and err=1, and SHALL be left only by reset.
REQ-026 The wait counter SHALL saturate at TIMEOUT and never wrap.

Reset
REQ-027 Asserting rst SHALL immediately force state=BOOT, counter=0 and err=0, including mid-wait or in HOLD.
REQ-028 While rst is high, outputs SHALL be imem_req=0, pc_freeze=1, pc_sel=0, ifid_flush=0, ifid_valid=0 and err=0.
REQ-029 The first FETCH SHALL occur in the second cycle after rst deasserts.

Configuration
REQ-030 With macro FETCH_SEQ_PERF_EN defined, the block SHALL add output stall_count (32 bits), counting cycles in FETCH or HOLD with pc_freeze=1.
REQ-031 With macro FETCH_SEQ_PERF_EN defined, the block SHALL add output redirect_count (32 bits), counting cycles with pc_sel=1.
REQ-032 stall_count and redirect_count SHALL saturate at all-ones and reset to 0.
REQ-033 Without FETCH_SEQ_PERF_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Shared package fetch_seq_pkg SHALL hold the state enumeration (BOOT, FETCH, HOLD, ERROR) and the constant PC_STEP=4.
REQ-035 The wait counter SHALL be sub-module fetch_seq_wait_timer, with inputs clk, rst, clr, inc and output expired at TIMEOUT.

Verification
REQ-036 Release rst with imem_ack=1 held -> cycle 1 BOOT with pc_freeze=1; cycles 2..9 give ifid_valid=1 and pc_freeze=0; 8 instructions.
REQ-037 In FETCH, hold imem_ack=0 for 3 cycles then 1 -> pc_freeze=1 for 3 cycles, then ifid_valid=1; err stays 0.
REQ-038 With TIMEOUT=15, hold imem_ack=0 for 15 cycles -> state ERROR, err=1, imem_req=0; rst pulse -> err=0, state BOOT.
REQ-039 Raise hazard_freeze for 2 cycles -> pc_freeze=1 and imem_req=0 in HOLD, FETCH resumes in the cycle after the drop.
REQ-040 Assert branch_taken and hazard_freeze together in HOLD -> same cycle pc_sel=1, ifid_flush=1 and pc_freeze=0; next state FETCH.
REQ-041 With FETCH_SEQ_PERF_EN defined, run REQ-037 then one branch -> stall_count=3 and redirect_count=1.
